// File: rtl/matmul_seq_ctrl.sv
// Fetch-side sequencer: diverts fetch into MATMUL microcode on STARTMATMUL2 and back on ENDMATMUL.
// Optional MATMUL residency watchdog is enabled by defining MATMUL_WDOG_EN.
//
// state     | meaning
// NORMAL    | fetching from normal imem, waiting for START
// DRAIN_IN  | fetch held while the pipeline empties, then redirect to microcode
// MATMUL    | fetching from matmul imem, waiting for END (or watchdog)
// DRAIN_OUT | fetch held while the pipeline empties, then return to saved PC
module matmul_seq_ctrl #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     DRAIN_CYCLES = 3,
    parameter logic [XLEN-1:0] UCODE_BASE   = '0,
    parameter int unsigned     WDOG_LIMIT   = 256
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] instr_d,
    input  logic            valid_d,
    input  logic            stall_d,
    input  logic [XLEN-1:0] pc_d,
    output logic            im_sel,
    output logic            stall_f,
    output logic            flush_fd,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] pc_backup,
    output logic            mm_active,
    output logic            seq_err,
    output logic            wdog_trip
);
    localparam int unsigned      CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [6:0]       OPC_MATMUL = 7'b1111010;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        DRAIN_IN  = 2'd1,
        MATMUL    = 2'd2,
        DRAIN_OUT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             im_sel_q, im_sel_d;
    logic [XLEN-1:0]  pc_backup_q, pc_backup_d;
    logic             seq_err_q, seq_err_d;
    logic             flush_c, redirect_c;
    logic             is_dec, is_start, is_end, wdog_fire;
    logic             unused_instr;

    assign is_dec       = valid_d && !stall_d && (instr_d[6:0] == OPC_MATMUL);
    assign is_start     = is_dec && (instr_d[14:12] == 3'b000);
    assign is_end       = is_dec && (instr_d[14:12] == 3'b111);
    assign unused_instr = ^{instr_d[XLEN-1:15], instr_d[11:7]};

`ifdef MATMUL_WDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_LIMIT - 1);

    logic [15:0] wdog_q, wdog_d;
    logic        wdog_trip_q, wdog_trip_d;

    // An END in the timeout cycle wins: normal exit, no trip.
    assign wdog_fire = (state_q == MATMUL) && (wdog_q == WDOG_LAST) && !is_end;

    always_comb begin
        wdog_d      = (state_q == MATMUL) ? wdog_q + 16'd1 : 16'd0;
        wdog_trip_d = wdog_trip_q | wdog_fire;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_q      <= 16'd0;
            wdog_trip_q <= 1'b0;
        end else begin
            wdog_q      <= wdog_d;
            wdog_trip_q <= wdog_trip_d;
        end
    end

    assign wdog_trip = wdog_trip_q;
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_LIMIT;
    assign wdog_fire   = 1'b0;
    assign wdog_trip   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        im_sel_d    = im_sel_q;
        pc_backup_d = pc_backup_q;
        seq_err_d   = seq_err_q;
        flush_c     = 1'b0;
        redirect_c  = 1'b0;
        case (state_q)
            NORMAL: begin
                if (is_start) begin
                    pc_backup_d = pc_d + XLEN'(4);
                    flush_c     = 1'b1;
                    cnt_d       = CNT_LOAD;
                    state_d     = DRAIN_IN;
                end else if (is_end) begin
                    seq_err_d = 1'b1;
                end
            end
            DRAIN_IN: begin
                if (is_start || is_end) seq_err_d = 1'b1;
                if (cnt_q == '0) begin
                    im_sel_d   = 1'b1;
                    redirect_c = 1'b1;
                    state_d    = MATMUL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MATMUL: begin
                if (is_start) seq_err_d = 1'b1;
                if (is_end || wdog_fire) begin
                    flush_c = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = DRAIN_OUT;
                end
            end
            DRAIN_OUT: begin
                if (is_start || is_end) seq_err_d = 1'b1;
                if (cnt_q == '0) begin
                    im_sel_d   = 1'b0;
                    redirect_c = 1'b1;
                    state_d    = NORMAL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= NORMAL;
            cnt_q       <= '0;
            im_sel_q    <= 1'b0;
            pc_backup_q <= '0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            im_sel_q    <= im_sel_d;
            pc_backup_q <= pc_backup_d;
            seq_err_q   <= seq_err_d;
        end
    end

    // flush_fd decodes live instr_d, so it is masked while reset is asserted.
    assign flush_fd    = reset_n && flush_c;
    assign pc_redirect = redirect_c;
    assign stall_f     = (state_q == DRAIN_IN) || (state_q == DRAIN_OUT);
    assign pc_target   = (state_q == DRAIN_OUT) ? pc_backup_q : UCODE_BASE;
    assign im_sel      = im_sel_q;
    assign pc_backup   = pc_backup_q;
    assign mm_active   = (state_q != NORMAL);
    assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench for matmul_seq_ctrl: timestamp-based reference model plus directed and random scenarios.
// Define MATMUL_WDOG_EN to also exercise the watchdog.
module tb_matmul_seq_ctrl;
    localparam int          DRAIN = 3;
    localparam int          WLIM  = 16;
    localparam logic [31:0] UBASE = 32'h0000_0000;
    localparam logic [6:0]  OPC   = 7'b1111010;
`ifdef MATMUL_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] instr_d = '0;
    logic        valid_d = 1'b0;
    logic        stall_d = 1'b0;
    logic [31:0] pc_d = '0;
    logic        im_sel, stall_f, flush_fd, pc_redirect, mm_active, seq_err, wdog_trip;
    logic [31:0] pc_target, pc_backup;

    matmul_seq_ctrl #(
        .XLEN(32), .DRAIN_CYCLES(DRAIN), .UCODE_BASE(UBASE), .WDOG_LIMIT(WLIM)
    ) dut (
        .clk(clk), .reset_n(reset_n), .instr_d(instr_d), .valid_d(valid_d),
        .stall_d(stall_d), .pc_d(pc_d), .im_sel(im_sel), .stall_f(stall_f),
        .flush_fd(flush_fd), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .pc_backup(pc_backup), .mm_active(mm_active), .seq_err(seq_err),
        .wdog_trip(wdog_trip)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: remembers only the cycle of the last accepted START/END and its kind.
    int          cyc = 0;
    int          ev_cyc = -100000;
    bit          ev_start = 1'b0;
    logic [31:0] m_backup = '0;
    bit          m_err = 1'b0;
    bit          m_trip = 1'b0;
    bit          e_normal, e_in_mm, e_st, e_en, e_fire, e_flush;
    logic [70:0] exp_v;

    function automatic void model_reset();
        ev_cyc   = cyc - 100000;
        ev_start = 1'b0;
        m_backup = '0;
        m_err    = 1'b0;
        m_trip   = 1'b0;
    endfunction

    function automatic void model_eval();
        int since = cyc - ev_cyc;
        bit dec   = valid_d && !stall_d && (instr_d[6:0] == OPC);
        bit drain = (since >= 1) && (since <= DRAIN);
        bit redir = (since == DRAIN);
        e_normal = !ev_start && (since > DRAIN);
        e_in_mm  = ev_start && (since > DRAIN);
        e_st     = dec && (instr_d[14:12] == 3'b000);
        e_en     = dec && (instr_d[14:12] == 3'b111);
        e_fire   = WDOG && e_in_mm && (since - DRAIN - 1 == WLIM - 1) && !e_en;
        e_flush  = (e_normal && e_st) || (e_in_mm && (e_en || e_fire));
        exp_v = {(ev_start ? (since > DRAIN) : (since <= DRAIN)), drain, e_flush, redir,
                 !e_normal, m_err, m_trip,
                 (redir ? (ev_start ? UBASE : m_backup) : 32'h0), m_backup};
    endfunction

    function automatic void model_step();
        model_eval();
        if (e_normal && e_st) begin
            ev_cyc   = cyc;
            ev_start = 1'b1;
            m_backup = pc_d + 32'd4;
        end else if (e_in_mm && (e_en || e_fire)) begin
            ev_cyc   = cyc;
            ev_start = 1'b0;
            if (e_fire) m_trip = 1'b1;
        end
        if (e_st && !e_normal) m_err = 1'b1;
        if (e_en && !e_in_mm) m_err = 1'b1;
    endfunction

    function automatic logic [70:0] obs();
        return {im_sel, stall_f, flush_fd, pc_redirect, mm_active, seq_err, wdog_trip,
                (pc_redirect ? pc_target : 32'h0), pc_backup};
    endfunction

    function automatic logic [31:0] mk(input logic [2:0] f3);
        logic [31:0] r;
        r        = $urandom;
        r[14:12] = f3;
        r[6:0]   = OPC;
        return r;
    endfunction

    function automatic logic [31:0] nop();
        logic [31:0] r;
        r      = $urandom;
        r[6:0] = 7'b0110011;
        return r;
    endfunction

    // Called just after a rising edge; returns at the following falling edge.
    task automatic drive(input logic [31:0] ins, input logic v, input logic s, input logic [31:0] pc);
        instr_d = ins;
        valid_d = v;
        stall_d = s;
        pc_d    = pc;
        @(negedge clk);
    endtask

    task automatic advance();
        if (reset_n) model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        drive(mk(3'b000), 1'b1, 1'b0, 32'h40);
        checks++;
        if ({im_sel, stall_f, flush_fd, pc_redirect, mm_active, seq_err, wdog_trip, pc_target, pc_backup} !== 71'h0) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=0", obs());
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        drive(mk(3'b000), 1'b1, 1'b0, 32'h100);
        advance();
        drive(nop(), 1'b0, 1'b0, 32'h0);
        advance();
        checks++;
        if (stall_f !== 1'b1 || mm_active !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_drain got stall_f=%b mm_active=%b exp 1 1", stall_f, mm_active);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({im_sel, stall_f, flush_fd, pc_redirect, mm_active, seq_err, wdog_trip, pc_target, pc_backup} !== 71'h0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=0", obs());
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(nop(), 1'b1, 1'b0, 32'h0);
            model_eval();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL reset_after_c%0d got=%h exp=%h", i, obs(), exp_v);
            end
            advance();
        end
        checks++;
        if (mm_active !== 1'b0 || stall_f !== 1'b0) begin
            failures++;
            $display("FAIL reset_normal got mm_active=%b stall_f=%b exp 0 0", mm_active, stall_f);
        end
    endtask

    task automatic run_transition(input string nm, input logic [31:0] ins, input logic [31:0] pc,
                                  output int stalls, output int redir_at, output logic [31:0] tgt);
        stalls   = 0;
        redir_at = -1;
        tgt      = 32'hDEAD_BEEF;
        drive(ins, 1'b1, 1'b0, pc);
        model_eval();
        checks++;
        if (obs() !== exp_v || flush_fd !== 1'b1) begin
            failures++;
            $display("FAIL %s_flush got=%h exp=%h", nm, obs(), exp_v);
        end
        advance();
        for (int i = 1; i <= 5; i++) begin
            drive(nop(), 1'b0, 1'b0, 32'h0);
            model_eval();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL %s_c%0d got=%h exp=%h", nm, i, obs(), exp_v);
            end
            if (stall_f) stalls++;
            if (pc_redirect) begin
                redir_at = i;
                tgt      = pc_target;
            end
            advance();
        end
    endtask

    task automatic test_entry();
        int stalls, redir_at;
        logic [31:0] tgt;
        run_transition("entry", mk(3'b000), 32'h0000_001C, stalls, redir_at, tgt);
        checks++;
        if (stalls != 3 || redir_at != 3 || tgt !== 32'h0) begin
            failures++;
            $display("FAIL entry_timing got stalls=%0d redir_at=%0d tgt=%h exp 3 3 0", stalls, redir_at, tgt);
        end
        checks++;
        if (im_sel !== 1'b1 || pc_backup !== 32'h0000_0020 || mm_active !== 1'b1) begin
            failures++;
            $display("FAIL entry_state got im_sel=%b pc_backup=%h mm_active=%b exp 1 00000020 1",
                     im_sel, pc_backup, mm_active);
        end
    endtask

    task automatic test_exit();
        int stalls, redir_at;
        logic [31:0] tgt;
        run_transition("exit", mk(3'b111), 32'h0000_0008, stalls, redir_at, tgt);
        checks++;
        if (stalls != 3 || redir_at != 3 || tgt !== 32'h0000_0020) begin
            failures++;
            $display("FAIL exit_timing got stalls=%0d redir_at=%0d tgt=%h exp 3 3 00000020", stalls, redir_at, tgt);
        end
        checks++;
        if (im_sel !== 1'b0 || mm_active !== 1'b0) begin
            failures++;
            $display("FAIL exit_state got im_sel=%b mm_active=%b exp 0 0", im_sel, mm_active);
        end
    endtask

    task automatic test_stall();
        int stalls, redir_at;
        logic [31:0] tgt;
        logic [31:0] ins;
        ins = mk(3'b000);
        for (int i = 0; i < 4; i++) begin
            drive(ins, 1'b1, 1'b1, 32'hFFFF_FFFC);
            model_eval();
            checks++;
            if (obs() !== exp_v || flush_fd !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold_c%0d got=%h exp=%h", i, obs(), exp_v);
            end
            advance();
        end
        checks++;
        if (mm_active !== 1'b0) begin
            failures++;
            $display("FAIL stall_no_entry got mm_active=%b exp 0", mm_active);
        end
        run_transition("stall_entry", ins, 32'hFFFF_FFFC, stalls, redir_at, tgt);
        checks++;
        if (stalls != 3 || im_sel !== 1'b1 || seq_err !== 1'b0 || pc_backup !== 32'h0) begin
            failures++;
            $display("FAIL stall_once got stalls=%0d im_sel=%b seq_err=%b pc_backup=%h exp 3 1 0 00000000",
                     stalls, im_sel, seq_err, pc_backup);
        end
        run_transition("stall_exit", mk(3'b111), 32'h0, stalls, redir_at, tgt);
    endtask

    task automatic test_errors();
        int stalls, redir_at;
        logic [31:0] tgt;
        drive(mk(3'b111), 1'b1, 1'b0, 32'h0000_0100);
        model_eval();
        checks++;
        if (obs() !== exp_v || flush_fd !== 1'b0) begin
            failures++;
            $display("FAIL err_orphan_end got=%h exp=%h", obs(), exp_v);
        end
        advance();
        checks++;
        if (seq_err !== 1'b1 || mm_active !== 1'b0) begin
            failures++;
            $display("FAIL err_orphan_state got seq_err=%b mm_active=%b exp 1 0", seq_err, mm_active);
        end
        run_transition("err_entry", mk(3'b000), 32'h0000_0200, stalls, redir_at, tgt);
        drive(mk(3'b000), 1'b1, 1'b0, 32'h0000_0300);
        model_eval();
        checks++;
        if (obs() !== exp_v || flush_fd !== 1'b0) begin
            failures++;
            $display("FAIL err_nested_start got=%h exp=%h", obs(), exp_v);
        end
        advance();
        checks++;
        if (mm_active !== 1'b1 || im_sel !== 1'b1 || pc_backup !== 32'h0000_0204 || seq_err !== 1'b1) begin
            failures++;
            $display("FAIL err_nested_state got mm=%b im_sel=%b pc_backup=%h seq_err=%b exp 1 1 00000204 1",
                     mm_active, im_sel, pc_backup, seq_err);
        end
        run_transition("err_exit", mk(3'b111), 32'h0, stalls, redir_at, tgt);
        checks++;
        if (seq_err !== 1'b1 || tgt !== 32'h0000_0204) begin
            failures++;
            $display("FAIL err_sticky got seq_err=%b tgt=%h exp 1 00000204", seq_err, tgt);
        end
    endtask

    task automatic test_random();
        int sel;
        logic [31:0] ins;
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2)       ins = mk(3'b000);
            else if (sel < 4)  ins = mk(3'b111);
            else if (sel == 4) ins = mk(3'($urandom_range(1, 6)));
            else               ins = nop();
            drive(ins, ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0), $urandom & 32'hFFFF_FFFC);
            model_eval();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL random_c%0d got=%h exp=%h", i, obs(), exp_v);
            end
            advance();
        end
    endtask

`ifdef MATMUL_WDOG_EN
    task automatic test_watchdog();
        int flush_at, redir_at;
        logic [31:0] tgt;
        reset_n = 1'b0;
        model_reset();
        #2 reset_n = 1'b1;
        // END lands on the 16th MATMUL cycle: ordinary exit.
        drive(mk(3'b000), 1'b1, 1'b0, 32'h0000_0400);
        advance();
        for (int i = 1; i <= 23; i++) begin
            drive((i == 19) ? mk(3'b111) : nop(), (i == 19), 1'b0, 32'h0);
            model_eval();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL wdog_edge_c%0d got=%h exp=%h", i, obs(), exp_v);
            end
            advance();
        end
        checks++;
        if (wdog_trip !== 1'b0 || mm_active !== 1'b0) begin
            failures++;
            $display("FAIL wdog_edge_state got trip=%b mm_active=%b exp 0 0", wdog_trip, mm_active);
        end
        // No END: forced exit after 16 MATMUL cycles.
        flush_at = -1;
        redir_at = -1;
        tgt      = 32'hDEAD_BEEF;
        drive(mk(3'b000), 1'b1, 1'b0, 32'h0000_0800);
        advance();
        for (int i = 1; i <= 30; i++) begin
            drive(nop(), 1'b1, 1'b0, 32'h0);
            model_eval();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL wdog_trip_c%0d got=%h exp=%h", i, obs(), exp_v);
            end
            if (flush_fd && flush_at < 0) flush_at = i;
            if (pc_redirect) begin
                redir_at = i;
                tgt      = pc_target;
            end
            advance();
        end
        checks++;
        if (flush_at != 19 || redir_at != 22 || tgt !== 32'h0000_0804 || wdog_trip !== 1'b1 || im_sel !== 1'b0) begin
            failures++;
            $display("FAIL wdog_exit got flush_at=%0d redir_at=%0d tgt=%h trip=%b im_sel=%b exp 19 22 00000804 1 0",
                     flush_at, redir_at, tgt, wdog_trip, im_sel);
        end
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_entry();
        test_exit();
        test_stall();
        test_errors();
        test_random();
`ifdef MATMUL_WDOG_EN
        test_watchdog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
